// File: rtl/doodle_vga_pkg.sv
// Raster timing constants for the 640x480@60 display; the game core places objects
// using the same visible-window bounds.
package doodle_vga_pkg;
  localparam int PIX_DIV  = 4;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;

  localparam int H_TOTAL     = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_ACT_START = H_SYNC + H_BP;
  localparam int H_ACT_END   = H_ACT_START + H_ACTIVE - 1;
  localparam int V_ACT_START = V_SYNC + V_BP;
  localparam int V_ACT_END   = V_ACT_START + V_ACTIVE - 1;

  typedef logic [9:0] cnt_t;
  typedef enum logic {IDLE, REQ} hs_state_t;

  function automatic logic in_range(input cnt_t c, input cnt_t lo, input cnt_t hi);
    return (c >= lo) && (c <= hi);
  endfunction
endpackage

// File: rtl/vga_timing_gen_pix_tick_div.sv
// Free-running pixel-clock divider: one-Clk tick every PIX_DIV Clks.
module pix_tick_div #(
  parameter int PIX_DIV = 4
) (
  input  logic Clk,
  input  logic Reset,
  output logic tick
);
  localparam int CW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(PIX_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LAST);
      cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, sync/bright decode and the once-per-frame vblank update
// handshake with the game core.
module vga_timing_gen #(
  parameter int PIX_DIV  = doodle_vga_pkg::PIX_DIV,
  parameter int H_SYNC   = doodle_vga_pkg::H_SYNC,
  parameter int H_BP     = doodle_vga_pkg::H_BP,
  parameter int H_ACTIVE = doodle_vga_pkg::H_ACTIVE,
  parameter int H_FP     = doodle_vga_pkg::H_FP,
  parameter int V_SYNC   = doodle_vga_pkg::V_SYNC,
  parameter int V_BP     = doodle_vga_pkg::V_BP,
  parameter int V_ACTIVE = doodle_vga_pkg::V_ACTIVE,
  parameter int V_FP     = doodle_vga_pkg::V_FP
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_ack,
  input  logic       ovr_clr,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       pix_tick,
  output logic       frame_req,
  output logic       overrun
);
  import doodle_vga_pkg::*;

  localparam cnt_t H_LAST   = cnt_t'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
  localparam cnt_t H_SY_END = cnt_t'(H_SYNC);
  localparam cnt_t V_SY_END = cnt_t'(V_SYNC);
  localparam cnt_t H_ACT_LO = cnt_t'(H_SYNC + H_BP);
  localparam cnt_t H_ACT_HI = cnt_t'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam cnt_t V_ACT_LO = cnt_t'(V_SYNC + V_BP);
  localparam cnt_t V_ACT_HI = cnt_t'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam cnt_t V_BLANK  = cnt_t'(V_SYNC + V_BP + V_ACTIVE);

  cnt_t      h_nxt, v_nxt;
  hs_state_t state;
  logic      vblank_start, deadline, miss;

  pix_tick_div #(.PIX_DIV(PIX_DIV)) u_div (
    .Clk   (Clk),
    .Reset (Reset),
    .tick  (pix_tick)
  );

  always_comb begin
    h_nxt = (hCount == H_LAST) ? '0 : hCount + cnt_t'(1);
    v_nxt = vCount;
    if (hCount == H_LAST) v_nxt = (vCount == V_LAST) ? '0 : vCount + cnt_t'(1);
  end

  // Decoding the next count keeps sync/bright aligned with the counters they describe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hCount <= '0;
      vCount <= '0;
      hSync  <= 1'b0;
      vSync  <= 1'b0;
      bright <= 1'b0;
    end else if (pix_tick) begin
      hCount <= h_nxt;
      vCount <= v_nxt;
      hSync  <= (h_nxt >= H_SY_END);
      vSync  <= (v_nxt >= V_SY_END);
      bright <= in_range(h_nxt, H_ACT_LO, H_ACT_HI) && in_range(v_nxt, V_ACT_LO, V_ACT_HI);
    end
  end

  assign vblank_start = pix_tick && (h_nxt == '0) && (v_nxt == V_BLANK);
  assign deadline     = pix_tick && (h_nxt == '0) && (v_nxt == V_ACT_LO);
  assign miss         = (state == REQ) && deadline && !frame_ack;

  // An ack arriving on the deadline Clk still counts as on time.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      frame_req <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (vblank_start) begin
          state     <= REQ;
          frame_req <= 1'b1;
        end
        REQ: if (frame_ack || deadline) begin
          state     <= IDLE;
          frame_req <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          frame_req <= 1'b0;
        end
      endcase
      if (miss)         overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end
endmodule
